// File: rtl/dram_if_pkg.sv
// Shared types and AXI constants for the DRAM read bridge.
package dram_if_pkg;

  // Bridge transaction states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // waiting for a request
    ST_CHECK = 2'd1,  // validating the captured request
    ST_ADDR  = 2'd2,  // AR channel handshake
    ST_DATA  = 2'd3   // receiving R beats
  } state_t;

  // 64-byte beats, incrementing bursts, normal non-cacheable bufferable.
  localparam logic [2:0] AXI_SIZE_64B      = 3'd6;
  localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY     = 2'b00;
  localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;
  localparam logic [2:0] AXI_PROT_DEFAULT  = 3'b000;

  // A burst may not cross a 4 KiB page; each beat covers 64 bytes.
  localparam int unsigned BOUNDARY_4K = 4096;
  localparam int unsigned BEAT_BYTES  = 64;

endpackage

// File: rtl/dram_read_bridge_if.sv
// Bundle of the request side (from the image pipeline) and the AXI4 read
// channels (toward PS DDR). The master modport is the bridge itself: it is
// the AXI master and answers the pipeline's requests. The slave modport is
// everything around it (requester plus AXI fabric).
interface dram_read_bridge_if #(
  parameter int DRAM_ADDR_WIDTH = 39,
  parameter int DRAM_DATA_WIDTH = 512,
  parameter int AXI_ID_WIDTH    = 6
);

  // Request / completion side
  logic                       dram_read_en;
  logic [DRAM_ADDR_WIDTH-1:0] dram_read_addr;
  logic [7:0]                 dram_read_len;
  logic                       dram_read_busy;
  logic [DRAM_DATA_WIDTH-1:0] dram_read_data;
  logic                       dram_read_data_valid;
  logic                       dram_read_error;

  // AXI4 read address channel
  logic [DRAM_ADDR_WIDTH-1:0] m_axi_araddr;
  logic [7:0]                 m_axi_arlen;
  logic [2:0]                 m_axi_arsize;
  logic [1:0]                 m_axi_arburst;
  logic [AXI_ID_WIDTH-1:0]    m_axi_arid;
  logic [3:0]                 m_axi_arcache;
  logic [2:0]                 m_axi_arprot;
  logic                       m_axi_arvalid;
  logic                       m_axi_arready;

  // AXI4 read data channel
  logic [DRAM_DATA_WIDTH-1:0] m_axi_rdata;
  logic [1:0]                 m_axi_rresp;
  logic                       m_axi_rlast;
  logic [AXI_ID_WIDTH-1:0]    m_axi_rid;
  logic                       m_axi_rvalid;
  logic                       m_axi_rready;

  modport master (
    input  dram_read_en, dram_read_addr, dram_read_len,
    output dram_read_busy, dram_read_data, dram_read_data_valid, dram_read_error,
    output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arid,
           m_axi_arcache, m_axi_arprot, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rid, m_axi_rvalid,
    output m_axi_rready
  );

  modport slave (
    output dram_read_en, dram_read_addr, dram_read_len,
    input  dram_read_busy, dram_read_data, dram_read_data_valid, dram_read_error,
    input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arid,
           m_axi_arcache, m_axi_arprot, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rid, m_axi_rvalid,
    input  m_axi_rready
  );

endinterface

// File: rtl/dram_read_bridge.sv
// DRAM read bridge: takes one (address, length) burst request at a time from
// the image pipeline, checks it against the 4 KiB page rule, issues it as an
// AXI4 INCR read burst and forwards each returned beat as a one-cycle pulse.
// Every output comes straight from a register or from the registered state.
module dram_read_bridge
  import dram_if_pkg::*;
#(
  parameter int DRAM_ADDR_WIDTH = 39,
  parameter int DRAM_DATA_WIDTH = 512,
  parameter int AXI_ID_WIDTH    = 6,
  parameter int AXI_ID          = 0
) (
  input  logic                clk_pixel,
  input  logic                dram_reader_reset_n,
  dram_read_bridge_if.master  bus
);

  localparam logic [AXI_ID_WIDTH-1:0] ARID = AXI_ID_WIDTH'(AXI_ID);

  state_t                     state_reg, state_next;
  logic [DRAM_ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [7:0]                 len_reg, len_next;
  logic [7:0]                 beat_cnt_reg, beat_cnt_next;
  logic [DRAM_DATA_WIDTH-1:0] data_reg, data_next;
  logic                       valid_reg, valid_next;
  logic                       error_reg, error_next;

  logic                       beat_is_last;
  logic                       beat_bad;

  // True when a burst starting at page offset 'offset' with len+1 beats runs
  // past the end of its 4 KiB page.
  function automatic logic crosses_4k(input logic [11:0] offset, input logic [7:0] len);
    logic [15:0] end_byte;
    end_byte = 16'(offset) + (16'(len) + 16'd1) * 16'(BEAT_BYTES);
    return end_byte > 16'(BOUNDARY_4K);
  endfunction

  // Beat classification in DATA: a beat ends the burst on rlast, or when the
  // counter reaches len even if rlast never comes. Any protocol deviation
  // marks the beat bad, but the data is still forwarded.
  always_comb begin
    beat_is_last = bus.m_axi_rlast || (beat_cnt_reg == len_reg);
    beat_bad     = (bus.m_axi_rresp != AXI_RESP_OKAY)
                || (bus.m_axi_rid != ARID)
                || (bus.m_axi_rlast && (beat_cnt_reg != len_reg))
                || (!bus.m_axi_rlast && (beat_cnt_reg == len_reg));
  end

  // Next-state and datapath update for the request/burst sequence.
  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    len_next      = len_reg;
    beat_cnt_next = beat_cnt_reg;
    data_next     = data_reg;
    valid_next    = 1'b0;
    error_next    = error_reg;

    case (state_reg)
      ST_IDLE: begin
        // busy is low in IDLE, so a high strobe here is an accepted request.
        if (bus.dram_read_en) begin
          addr_next  = {bus.dram_read_addr[DRAM_ADDR_WIDTH-1:6], 6'd0};
          len_next   = bus.dram_read_len;
          state_next = ST_CHECK;
        end
      end

      ST_CHECK: begin
        if (crosses_4k(addr_reg[11:0], len_reg)) begin
          error_next = 1'b1;
          state_next = ST_IDLE;
        end else begin
          state_next = ST_ADDR;
        end
      end

      ST_ADDR: begin
        if (bus.m_axi_arready) begin
          beat_cnt_next = 8'd0;
          state_next    = ST_DATA;
        end
      end

      ST_DATA: begin
        if (bus.m_axi_rvalid) begin
          data_next     = bus.m_axi_rdata;
          valid_next    = 1'b1;
          beat_cnt_next = beat_cnt_reg + 8'd1;
          if (beat_bad) begin
            error_next = 1'b1;
          end
          if (beat_is_last) begin
            state_next = ST_IDLE;
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_pixel) begin
    if (!dram_reader_reset_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Captured request, beat counter, forwarded beat and sticky error flag.
  always_ff @(posedge clk_pixel) begin
    if (!dram_reader_reset_n) begin
      addr_reg     <= '0;
      len_reg      <= '0;
      beat_cnt_reg <= '0;
      data_reg     <= '0;
      valid_reg    <= 1'b0;
      error_reg    <= 1'b0;
    end else begin
      addr_reg     <= addr_next;
      len_reg      <= len_next;
      beat_cnt_reg <= beat_cnt_next;
      data_reg     <= data_next;
      valid_reg    <= valid_next;
      error_reg    <= error_next;
    end
  end

  // Completion side.
  assign bus.dram_read_busy       = (state_reg != ST_IDLE);
  assign bus.dram_read_data       = data_reg;
  assign bus.dram_read_data_valid = valid_reg;
  assign bus.dram_read_error      = error_reg;

  // AR channel: fields come from the captured request and stay stable while
  // arvalid is held in ADDR.
  assign bus.m_axi_araddr  = addr_reg;
  assign bus.m_axi_arlen   = len_reg;
  assign bus.m_axi_arsize  = AXI_SIZE_64B;
  assign bus.m_axi_arburst = AXI_BURST_INCR;
  assign bus.m_axi_arid    = ARID;
  assign bus.m_axi_arcache = AXI_CACHE_DEFAULT;
  assign bus.m_axi_arprot  = AXI_PROT_DEFAULT;
  assign bus.m_axi_arvalid = (state_reg == ST_ADDR);

  // R channel: the sink never stalls, so rready is simply "in DATA".
  assign bus.m_axi_rready  = (state_reg == ST_DATA);

endmodule
